// File: rtl/boot_rom_bus_if.sv
// rtl/boot_rom_bus_if.sv - boot ROM bus front end: credit-limited grants, ROM CSN/A drive, in-order response FIFO
module boot_rom_bus_if #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_8000,
  parameter int          ROM_AW     = 10,
  parameter int          ROM_WORDS  = 1024,
  parameter int          RESP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [31:0]       rdata_o,
  output logic              rerr_o,
  output logic              rom_csn_o,
  output logic [ROM_AW-1:0] rom_a_o,
  input  logic [31:0]       rom_q_i
);

  localparam int          CW = $clog2(RESP_DEPTH + 1);
  localparam int          PW = $clog2(RESP_DEPTH);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + (33'(ROM_WORDS) << 2);

  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [32:0]       mem [RESP_DEPTH];
  logic              inflight;
  logic              inflight_err;
  logic [ROM_AW-1:0] rom_a_q;
  logic              pop;
  logic              push;
  logic              in_range;
  logic              hit;
  logic [CW:0]       occupancy;
  logic [ROM_AW-1:0] word_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts queued entries plus the one in flight; a same-cycle pop frees a slot.
  always_comb begin
    pop       = (count != '0) & rready_i;
    push      = inflight;
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    gnt_o     = req_i & ~RST & (occupancy < (CW+1)'(RESP_DEPTH));
    in_range  = ({1'b0, addr_i} >= LO) && ({1'b0, addr_i} < HI);
    hit       = gnt_o & ~we_i & in_range;
    word_idx  = addr_i[ROM_AW+1:2];
  end

  assign rom_csn_o = ~hit;
  assign rom_a_o   = hit ? word_idx : rom_a_q;
  assign rvalid_o  = (count != '0);
  assign rdata_o   = rvalid_o ? mem[rd_ptr][32:1] : 32'h0;
  assign rerr_o    = rvalid_o & mem[rd_ptr][0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      rom_a_q      <= '0;
    end else begin
      inflight     <= gnt_o;
      inflight_err <= ~hit;
      if (hit)  rom_a_q <= word_idx;
      if (push) wr_ptr  <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr  <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ROM Q is valid the cycle after CSN was low; errors store zero data.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= {(inflight_err ? 32'h0 : rom_q_i), inflight_err};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(push && !pop && count == CW'(RESP_DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: tb/tb_boot_rom_bus_if.sv
// tb/tb_boot_rom_bus_if.sv - scoreboard bench for boot_rom_bus_if with a registered-address ROM model
module tb_boot_rom_bus_if;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic        gnt;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [31:0] rdata;
  logic        rerr;
  logic        rom_csn;
  logic [9:0]  rom_a;
  logic [31:0] rom_q = 32'h0;

  always #5 CLK = ~CLK;

  boot_rom_bus_if dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_i     (req),
    .addr_i    (addr),
    .we_i      (we),
    .gnt_o     (gnt),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .rdata_o   (rdata),
    .rerr_o    (rerr),
    .rom_csn_o (rom_csn),
    .rom_a_o   (rom_a),
    .rom_q_i   (rom_q)
  );

  // ROM word i holds C0DE_0000 | i; deselected reads return a poison pattern.
  always @(posedge CLK) begin
    rom_q <= rom_csn ? 32'hBAD0_BAD0 : (32'hC0DE_0000 | {22'h0, rom_a});
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_pop_cyc = -1;
  int    g, g0, gc;
  logic  granted;

  always @(posedge CLK) cyc++;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    resp_t e;
    if (!RST && rvalid && rready) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_resp", rdata, 32'h0);
      end else begin
        e = sb.pop_front();
        chk(rdata == e.data, "rdata", rdata, e.data);
        chk(rerr == e.err, "rerr", {31'h0, rerr}, {31'h0, e.err});
      end
      last_pop_cyc = cyc;
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] ed,
                       input logic ee, output int gcyc);
    bit done;
    done = 1'b0;
    gcyc = -1;
    req  = 1'b1;
    addr = a;
    we   = w;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (gnt) begin
        sb.push_back(resp_t'{ed, ee});
        gcyc = cyc;
        done = 1'b1;
        chk(rom_csn == ee, "rom_csn", {31'h0, rom_csn}, {31'h0, ee});
        if (!ee) chk(rom_a == a[11:2], "rom_a", {22'h0, rom_a}, {22'h0, a[11:2]});
      end
      @(posedge CLK);
      #1;
    end
    if (!done) chk(1'b0, "grant_timeout", 32'h0, 32'h1);
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CLK);
    chk(sb.size() == 0, "drain_timeout", sb.size(), 32'h0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with a pending request
    req  = 1'b1;
    addr = 32'h0000_8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk(gnt == 1'b0, "rst_gnt", {31'h0, gnt}, 32'h0);
      chk(rom_csn == 1'b1, "rst_csn", {31'h0, rom_csn}, 32'h1);
      chk(rvalid == 1'b0, "rst_rvalid", {31'h0, rvalid}, 32'h0);
    end
    chk(rdata == 32'h0, "rst_rdata", rdata, 32'h0);
    chk(rom_a == 10'h0, "rst_rom_a", {22'h0, rom_a}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    req = 1'b0;

    // 2: single read, fixed latency 2
    issue(32'h0000_8004, 1'b0, 32'hC0DE_0001, 1'b0, g);
    drain();
    chk(last_pop_cyc == g + 2, "latency", last_pop_cyc, g + 2);

    // 3: burst of 8, no bubbles
    for (int k = 0; k < 8; k++) begin
      issue(32'h0000_8000 + 32'(4 * k), 1'b0, 32'hC0DE_0000 + 32'(k), 1'b0, g);
      if (k == 0) g0 = g;
    end
    chk(g - g0 == 7, "burst_gnt_span", g - g0, 32'd7);
    drain();
    chk(last_pop_cyc == g0 + 9, "burst_rvalid_span", last_pop_cyc, g0 + 9);

    // 4: backpressure
    rready  = 1'b0;
    req     = 1'b1;
    addr    = 32'h0000_8010;
    gc      = 0;
    granted = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (gnt) begin
        sb.push_back(resp_t'{32'hC0DE_0004 + 32'(gc), 1'b0});
        gc++;
        granted = 1'b1;
      end
      if (i >= 3) begin
        chk(rvalid == 1'b1, "bp_rvalid", {31'h0, rvalid}, 32'h1);
        chk(rdata == 32'hC0DE_0004, "bp_hold", rdata, 32'hC0DE_0004);
      end
      @(posedge CLK);
      #1;
      if (granted) addr = addr + 32'h4;
      granted = 1'b0;
    end
    chk(gc == 2, "bp_grants", gc, 32'd2);
    rready = 1'b1;
    issue(32'h0000_8018, 1'b0, 32'hC0DE_0006, 1'b0, g);
    drain();

    // 5: errors and top word
    issue(32'h0000_9000, 1'b0, 32'h0, 1'b1, g);
    issue(32'h0000_7FFC, 1'b0, 32'h0, 1'b1, g);
    issue(32'h0000_8000, 1'b1, 32'h0, 1'b1, g);
    issue(32'h0000_8FFC, 1'b0, 32'hC0DE_03FF, 1'b0, g);
    drain();

    // 6: reset with two responses queued
    rready = 1'b0;
    issue(32'h0000_8000, 1'b0, 32'hC0DE_0000, 1'b0, g);
    issue(32'h0000_8004, 1'b0, 32'hC0DE_0001, 1'b0, g);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    req = 1'b1;
    @(negedge CLK);
    chk(gnt == 1'b0, "midrst_gnt", {31'h0, gnt}, 32'h0);
    chk(rom_csn == 1'b1, "midrst_csn", {31'h0, rom_csn}, 32'h1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    req = 1'b0;
    sb.delete();
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk(rvalid == 1'b0, "post_rst_rvalid", {31'h0, rvalid}, 32'h0);
    end
    @(posedge CLK);
    #1;
    issue(32'h0000_8008, 1'b0, 32'hC0DE_0002, 1'b0, g);
    drain();

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
